// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the 5-stage pipeline hazard logic:
//   - hz_state_e     : hazard controller FSM state (BOOT, RUN, MEM_WAIT)
//   - FWD_*          : EX-stage operand forwarding select encodings
//   - REG_WRITE_NONE : write-type code meaning "stage does not write rd"
//   - fwd_sel()      : forwarding select for one EX operand
// Optional feature macro used by users of this package: HAZARD_PERF_EN.
// -----------------------------------------------------------------------------
package pipe_pkg;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  localparam logic [2:0] REG_WRITE_NONE = 3'b000;

  // MEM result is the younger value, so it wins over WB when both match.
  // x0 is hardwired zero and is never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic       used,
    input logic [4:0] rd_m,
    input logic [2:0] wr_m,
    input logic [4:0] rd_w,
    input logic [2:0] wr_w
  );
    logic [1:0] sel;
    if (used && (wr_m != REG_WRITE_NONE) && (rd_m != 5'd0) && (rd_m == rs)) begin
      sel = FWD_MEM;
    end else if (used && (wr_w != REG_WRITE_NONE) && (rd_w != 5'd0) && (rd_w == rs)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

endpackage

// File: rtl/pipe_fwd_unit.sv
// -----------------------------------------------------------------------------
// pipe_fwd_unit
// Purely combinational EX-stage forwarding select generation.
// Ports:
//   boot_i                 : controller in BOOT, forces both selects to FWD_RF
//   rs1e_i, rs2e_i         : EX source registers
//   reg_read_e_i           : EX operand use, [1]=rs1, [0]=rs2
//   rd_m_i, reg_write_m_i  : MEM destination and write-type code
//   rd_w_i, reg_write_w_i  : WB destination and write-type code
//   forward1e_o/forward2e_o: operand selects (00 RF, 10 MEM, 01 WB)
// -----------------------------------------------------------------------------
module pipe_fwd_unit
  import pipe_pkg::*;
(
  input  logic       boot_i,
  input  logic [4:0] rs1e_i,
  input  logic [4:0] rs2e_i,
  input  logic [1:0] reg_read_e_i,
  input  logic [4:0] rd_m_i,
  input  logic [2:0] reg_write_m_i,
  input  logic [4:0] rd_w_i,
  input  logic [2:0] reg_write_w_i,
  output logic [1:0] forward1e_o,
  output logic [1:0] forward2e_o
);

  // Select generation for both operands, suppressed while booting.
  always_comb begin
    forward1e_o = FWD_RF;
    forward2e_o = FWD_RF;
    if (boot_i) begin
      forward1e_o = FWD_RF;
      forward2e_o = FWD_RF;
    end else begin
      forward1e_o = fwd_sel(rs1e_i, reg_read_e_i[1], rd_m_i, reg_write_m_i, rd_w_i, reg_write_w_i);
      forward2e_o = fwd_sel(rs2e_i, reg_read_e_i[0], rd_m_i, reg_write_m_i, rd_w_i, reg_write_w_i);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Central hazard controller for the IF/ID/EX/MEM/WB pipeline.
// Ports:
//   clk, rst_n               : clock (rising edge), async active-low reset
//   Rs1D/Rs2D/RegReadD       : ID operands and their use flags
//   Rs1E/Rs2E/RegReadE       : EX operands and their use flags
//   RdE/MemToRegE            : EX destination, EX is a load
//   BranchE/JalrE/JalD       : control transfers (EX taken branch, EX jalr, ID jal)
//   RdM/RdW/RegWriteM/W      : MEM/WB destinations and write-type codes
//   mem_req/mem_ack          : data-memory handshake from the MEM stage
//   Stall*/Flush*            : segment register hold / clear controls
//   Forward1E/Forward2E      : EX forwarding selects
//   mem_err                  : one-cycle pulse on data-memory timeout
// Optional feature: define HAZARD_PERF_EN to add perf_stall_cnt and
// perf_flush_cnt saturating event counters.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int BOOT_CYCLES = 2,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [1:0] RegReadD,
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [1:0] RegReadE,
  input  logic [4:0] RdE,
  input  logic       MemToRegE,
  input  logic       BranchE,
  input  logic       JalrE,
  input  logic       JalD,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic [2:0] RegWriteM,
  input  logic [2:0] RegWriteW,
  input  logic       mem_req,
  input  logic       mem_ack,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       StallM,
  output logic       StallW,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushM,
  output logic       FlushW,
  output logic [1:0] Forward1E,
  output logic [1:0] Forward2E,
  output logic       mem_err
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_CNT   = CNT_W'(MEM_TIMEOUT);

  hz_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             load_use_s;

  // Counter never wraps: it sticks at all-ones.
  assign cnt_inc_s = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_ONE);

  // x0 never creates a load-use dependency.
  assign load_use_s = MemToRegE && (RdE != 5'd0) &&
                      ((RegReadD[1] && (Rs1D == RdE)) || (RegReadD[0] && (Rs2D == RdE)));

  // Next-state and pipeline control decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    StallF  = 1'b0;
    StallD  = 1'b0;
    StallE  = 1'b0;
    StallM  = 1'b0;
    StallW  = 1'b0;
    FlushD  = 1'b0;
    FlushE  = 1'b0;
    FlushM  = 1'b0;
    FlushW  = 1'b0;
    mem_err = 1'b0;
    case (state_q)
      BOOT: begin
        StallF = 1'b1;
        FlushD = 1'b1;
        FlushE = 1'b1;
        FlushM = 1'b1;
        FlushW = 1'b1;
        if (cnt_q >= BOOT_LAST) begin
          state_d = RUN;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      RUN: begin
        cnt_d = CNT_ZERO;
        if (mem_req && !mem_ack) begin
          // The access in MEM cannot complete: freeze F..M, bubble into WB.
          StallF  = 1'b1;
          StallD  = 1'b1;
          StallE  = 1'b1;
          StallM  = 1'b1;
          FlushW  = 1'b1;
          state_d = MEM_WAIT;
          cnt_d   = CNT_ONE;
        end else if (BranchE || JalrE) begin
          FlushD = 1'b1;
          FlushE = 1'b1;
        end else if (load_use_s) begin
          StallF = 1'b1;
          StallD = 1'b1;
          FlushE = 1'b1;
        end else if (JalD) begin
          FlushD = 1'b1;
        end else begin
          FlushD = 1'b0;
        end
      end
      MEM_WAIT: begin
        if (mem_ack) begin
          // Ack cycle still holds; the pipeline advances at the next edge.
          StallF  = 1'b1;
          StallD  = 1'b1;
          StallE  = 1'b1;
          StallM  = 1'b1;
          FlushW  = 1'b1;
          state_d = RUN;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q >= TMO_CNT) begin
          // Abort: let the access leave MEM into a cleared WB (dropped),
          // refill MEM with a bubble, keep older stages frozen.
          StallF  = 1'b1;
          StallD  = 1'b1;
          StallE  = 1'b1;
          FlushM  = 1'b1;
          FlushW  = 1'b1;
          mem_err = 1'b1;
          state_d = RUN;
          cnt_d   = CNT_ZERO;
        end else begin
          StallF = 1'b1;
          StallD = 1'b1;
          StallE = 1'b1;
          StallM = 1'b1;
          FlushW = 1'b1;
          cnt_d  = cnt_inc_s;
        end
      end
      default: begin
        StallF  = 1'b1;
        FlushD  = 1'b1;
        FlushE  = 1'b1;
        FlushM  = 1'b1;
        FlushW  = 1'b1;
        state_d = BOOT;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // FSM state and wait/boot counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      cnt_q   <= CNT_ZERO;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  pipe_fwd_unit u_fwd (
    .boot_i        (state_q == BOOT),
    .rs1e_i        (Rs1E),
    .rs2e_i        (Rs2E),
    .reg_read_e_i  (RegReadE),
    .rd_m_i        (RdM),
    .reg_write_m_i (RegWriteM),
    .rd_w_i        (RdW),
    .reg_write_w_i (RegWriteW),
    .forward1e_o   (Forward1E),
    .forward2e_o   (Forward2E)
  );

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_q, perf_flush_q;

  // Saturating stall/flush event counters, idle during BOOT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_q <= 32'd0;
      perf_flush_q <= 32'd0;
    end else begin
      if ((state_q != BOOT) && StallD && (perf_stall_q != 32'hFFFF_FFFF)) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end else begin
        perf_stall_q <= perf_stall_q;
      end
      if ((state_q == RUN) && (FlushD || FlushE) && (perf_flush_q != 32'hFFFF_FFFF)) begin
        perf_flush_q <= perf_flush_q + 32'd1;
      end else begin
        perf_flush_q <= perf_flush_q;
      end
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

endmodule
